// File: rtl/logica_pkg.sv
// Shared encodings for the bit-serial logic sequencer: operation codes,
// walk direction and controller states.
package logica_pkg;

    localparam logic [1:0] OP_AND    = 2'b00;
    localparam logic [1:0] OP_OR     = 2'b01;
    localparam logic [1:0] OP_ANDN   = 2'b10;
    localparam logic [1:0] OP_ILEGAL = 2'b11;

    localparam logic DIR_DER = 1'b0;
    localparam logic DIR_IZQ = 1'b1;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        PROCESA = 2'd1,
        FIN     = 2'd2
    } estado_t;

endpackage

// File: rtl/unidad_logica_bit.sv
// Combinational 1-bit logic cell: AND, OR or (~a)&b selected by op.
// This is the single resource the sequencer time-shares across all bits.
module unidad_logica_bit
    import logica_pkg::*;
(
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic [1:0] op,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (op)
            OP_AND:  y = a_bit & b_bit;
            OP_OR:   y = a_bit | b_bit;
            OP_ANDN: y = (~a_bit) & b_bit;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/secuenciador_logico_serial.sv
// Bit-serial controller: walks two ANCHO-bit operands one bit per clock
// through a shared 1-bit logic cell and returns the parallel result.
module secuenciador_logico_serial
    import logica_pkg::*;
#(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic [1:0]       op,
    input  logic             dir,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    output logic             ocupado,
    output logic             listo,
    output logic             error_op,
    output logic [ANCHO-1:0] resultado
);

    localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;
    localparam logic [CW-1:0] CNT_ULTIMO = CW'(ANCHO - 1);

    estado_t          estado;
    logic [ANCHO-1:0] reg_a;
    logic [ANCHO-1:0] reg_b;
    logic [ANCHO-1:0] sombra;
    logic [ANCHO-1:0] sombra_sig;
    logic [1:0]       op_q;
    logic             dir_q;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    idx;
    logic             bit_a;
    logic             bit_b;
    logic             bit_y;

    // MSB-first walk writes bit ANCHO-1-cnt so both directions land f(a[i],b[i]) in bit i.
    always_comb begin
        bit_a      = dir_q ? reg_a[ANCHO-1] : reg_a[0];
        bit_b      = dir_q ? reg_b[ANCHO-1] : reg_b[0];
        idx        = dir_q ? (CNT_ULTIMO - cnt) : cnt;
        sombra_sig = sombra;
        sombra_sig[idx] = bit_y;
    end

    unidad_logica_bit u_celda (
        .a_bit (bit_a),
        .b_bit (bit_b),
        .op    (op_q),
        .y     (bit_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= REPOSO;
            reg_a     <= '0;
            reg_b     <= '0;
            sombra    <= '0;
            op_q      <= OP_AND;
            dir_q     <= DIR_DER;
            cnt       <= '0;
            ocupado   <= 1'b0;
            listo     <= 1'b0;
            error_op  <= 1'b0;
            resultado <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    listo    <= 1'b0;
                    error_op <= 1'b0;
                    if (inicio) begin
                        ocupado <= 1'b1;
                        if (op == OP_ILEGAL) begin
                            estado   <= FIN;
                            listo    <= 1'b1;
                            error_op <= 1'b1;
                        end else begin
                            estado <= PROCESA;
                            reg_a  <= a;
                            reg_b  <= b;
                            op_q   <= op;
                            dir_q  <= dir;
                            cnt    <= '0;
                            sombra <= '0;
                        end
                    end
                end
                PROCESA: begin
                    if (dir_q == DIR_IZQ) begin
                        reg_a <= reg_a << 1;
                        reg_b <= reg_b << 1;
                    end else begin
                        reg_a <= reg_a >> 1;
                        reg_b <= reg_b >> 1;
                    end
                    sombra <= sombra_sig;
                    // Result is published on entry to FIN so it is valid while listo is high.
                    if (cnt == CNT_ULTIMO) begin
                        estado    <= FIN;
                        listo     <= 1'b1;
                        resultado <= sombra_sig;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    estado   <= REPOSO;
                    listo    <= 1'b0;
                    error_op <= 1'b0;
                    ocupado  <= 1'b0;
                end
                default: begin
                    estado   <= REPOSO;
                    listo    <= 1'b0;
                    error_op <= 1'b0;
                    ocupado  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_logico_serial.sv
// Directed self-checking bench for secuenciador_logico_serial (ANCHO=8).
module tb_secuenciador_logico_serial;

    logic       clk;
    logic       rst_n;
    logic       inicio;
    logic [1:0] op;
    logic       dir;
    logic [7:0] a;
    logic [7:0] b;
    logic       ocupado;
    logic       listo;
    logic       error_op;
    logic [7:0] resultado;

    int checks   = 0;
    int failures = 0;

    secuenciador_logico_serial #(.ANCHO(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inicio    (inicio),
        .op        (op),
        .dir       (dir),
        .a         (a),
        .b         (b),
        .ocupado   (ocupado),
        .listo     (listo),
        .error_op  (error_op),
        .resultado (resultado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a run and watches 20 cycles; cycle 1 is the one after the accepting edge.
    task automatic run(input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] top,
                       input logic tdir, input bit scramble,
                       output int listo_cyc, output int occ, output logic err,
                       output logic [7:0] res);
        listo_cyc = -1;
        occ = 0;
        err = 1'bx;
        res = 'x;
        @(negedge clk);
        a = ta; b = tb_; op = top; dir = tdir; inicio = 1'b1;
        @(posedge clk);
        #1 inicio = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (ocupado) occ++;
            if (listo && listo_cyc < 0) begin
                listo_cyc = c;
                err = error_op;
                res = resultado;
            end
            if (scramble) begin
                a   = 8'($urandom);
                b   = 8'($urandom);
                op  = 2'($urandom);
                dir = 1'($urandom);
            end
            @(posedge clk);
            #1;
        end
    endtask

    int         lc, oc, nl;
    int         t_listo[$];
    logic       e;
    logic [7:0] r;
    logic       bad_res;
    logic       any_err;

    initial begin
        rst_n = 1'b0; inicio = 1'b0; op = 2'b00; dir = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ocupado", 32'(ocupado), 32'd0);
        check("reset_listo", 32'(listo), 32'd0);
        check("reset_error", 32'(error_op), 32'd0);
        check("reset_resultado", 32'(resultado), 32'h00);
        @(negedge clk) rst_n = 1'b1;

        // 1: AND LSB-first
        run(8'hF0, 8'h3C, 2'b00, 1'b0, 1'b0, lc, oc, e, r);
        check("and_der_listo_cyc", 32'(lc), 32'd9);
        check("and_der_ocupado_cycles", 32'(oc), 32'd9);
        check("and_der_res", 32'(r), 32'h30);
        check("and_der_err", 32'(e), 32'd0);
        check("and_der_hold", 32'(resultado), 32'h30);

        // 2: OR / ANDN in both directions
        run(8'hF0, 8'h3C, 2'b01, 1'b1, 1'b0, lc, oc, e, r);
        check("or_izq_res", 32'(r), 32'hFC);
        check("or_izq_listo_cyc", 32'(lc), 32'd9);
        run(8'hF0, 8'h3C, 2'b01, 1'b0, 1'b0, lc, oc, e, r);
        check("or_der_res", 32'(r), 32'hFC);
        run(8'hF0, 8'h3C, 2'b10, 1'b0, 1'b0, lc, oc, e, r);
        check("andn_der_res", 32'(r), 32'h0C);
        run(8'hF0, 8'h3C, 2'b10, 1'b1, 1'b0, lc, oc, e, r);
        check("andn_izq_res", 32'(r), 32'h0C);
        run(8'h96, 8'hA5, 2'b10, 1'b1, 1'b0, lc, oc, e, r);
        check("andn_izq_asym_res", 32'(r), 32'h21);
        run(8'hF0, 8'h3C, 2'b10, 1'b1, 1'b0, lc, oc, e, r);

        // 3: illegal op keeps previous result
        run(8'hFF, 8'hFF, 2'b11, 1'b0, 1'b0, lc, oc, e, r);
        check("ilegal_listo_cyc", 32'(lc), 32'd1);
        check("ilegal_err", 32'(e), 32'd1);
        check("ilegal_res", 32'(r), 32'h0C);
        check("ilegal_ocupado_cycles", 32'(oc), 32'd1);
        check("ilegal_err_cleared", 32'(error_op), 32'd0);

        // 4: inicio held high -> runs every 10 cycles
        @(negedge clk);
        a = 8'hAA; b = 8'hFF; op = 2'b00; dir = 1'b0; inicio = 1'b1;
        @(posedge clk);
        #1;
        bad_res = 1'b0; any_err = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (listo) begin
                t_listo.push_back(c);
                if (resultado !== 8'hAA) bad_res = 1'b1;
                if (error_op !== 1'b0) any_err = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        inicio = 1'b0;
        check("b2b_count", 32'(t_listo.size()), 32'd3);
        if (t_listo.size() == 3) begin
            check("b2b_t0", 32'(t_listo[0]), 32'd9);
            check("b2b_t1", 32'(t_listo[1]), 32'd19);
            check("b2b_t2", 32'(t_listo[2]), 32'd29);
        end
        check("b2b_res", 32'(bad_res), 32'd0);
        check("b2b_err", 32'(any_err), 32'd0);
        repeat (15) @(posedge clk);
        #1;
        check("b2b_idle", 32'(ocupado), 32'd0);

        // 5: async reset mid-run
        @(negedge clk);
        a = 8'hF0; b = 8'h3C; op = 2'b01; dir = 1'b0; inicio = 1'b1;
        @(posedge clk);
        #1 inicio = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ocupado", 32'(ocupado), 32'd0);
        check("rst_mid_listo", 32'(listo), 32'd0);
        check("rst_mid_resultado", 32'(resultado), 32'h00);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        nl = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (listo || ocupado) nl++;
        end
        check("rst_no_listo", 32'(nl), 32'd0);
        run(8'hF0, 8'h3C, 2'b00, 1'b0, 1'b0, lc, oc, e, r);
        check("rst_after_listo_cyc", 32'(lc), 32'd9);
        check("rst_after_res", 32'(r), 32'h30);

        // 6: inputs scrambled during PROCESA
        run(8'h0F, 8'hFF, 2'b01, 1'b1, 1'b1, lc, oc, e, r);
        check("scramble_res", 32'(r), 32'hFF);
        check("scramble_listo_cyc", 32'(lc), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
